// File: rtl/main.sv
// Registered 16-bit unsigned arithmetic/logic/scientific unit with one cycle of latency.
// Define SCI_OPS_EN to build the square, sqrt and factorial operations.
module main (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] inp1,
   input  logic [15:0] inp2,
   input  logic [4:0]  select,
   output logic [15:0] a,
   output logic [15:0] b
);

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_AND  = 5'b00100;
   localparam logic [4:0] OP_OR   = 5'b00101;
   localparam logic [4:0] OP_XOR  = 5'b00110;
   localparam logic [4:0] OP_NOT  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_MAX  = 5'b01010;
`ifdef SCI_OPS_EN
   localparam logic [4:0] OP_SQR  = 5'b01011;
   localparam logic [4:0] OP_SQRT = 5'b01100;
   localparam logic [4:0] OP_FACT = 5'b01101;

   // Bitwise greedy root: keep each candidate bit whose square still fits.
   function automatic logic [7:0] isqrt(input logic [15:0] x);
      logic [7:0]  root;
      logic [7:0]  cand;
      logic [15:0] sq;
      root = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         cand = root | (8'd1 << i);
         sq   = 16'(cand) * 16'(cand);
         if (sq <= x)
            root = cand;
      end
      return root;
   endfunction

   // Factorial saturates to all-ones past 8!, the largest that fits in 16 bits.
   function automatic logic [15:0] fact_sat(input logic [15:0] n);
      logic [15:0] f;
      unique case (n)
         16'd0, 16'd1: f = 16'd1;
         16'd2:        f = 16'd2;
         16'd3:        f = 16'd6;
         16'd4:        f = 16'd24;
         16'd5:        f = 16'd120;
         16'd6:        f = 16'd720;
         16'd7:        f = 16'd5040;
         16'd8:        f = 16'd40320;
         default:      f = 16'hFFFF;
      endcase
      return f;
   endfunction
`endif

   logic [16:0] sum_p0;
   logic [15:0] diff_p0;
   logic [31:0] prod_p0;
   logic [31:0] shl_p0;
   logic [15:0] quot_p0;
   logic [15:0] rem_p0;
   logic [15:0] res_a_p0;
   logic [15:0] res_b_p0;
`ifdef SCI_OPS_EN
   logic [31:0] sqr_p0;
   logic [7:0]  root_p0;
   logic [15:0] root_sq_p0;
`endif

   always_comb begin
      sum_p0  = {1'b0, inp1} + {1'b0, inp2};
      diff_p0 = inp1 - inp2;
      prod_p0 = 32'(inp1) * 32'(inp2);
      shl_p0  = {16'h0000, inp1} << inp2[3:0];
      // Divide-by-zero returns all-ones quotient and passes the dividend through.
      if (inp2 == 16'd0) begin
         quot_p0 = 16'hFFFF;
         rem_p0  = inp1;
      end else begin
         quot_p0 = inp1 / inp2;
         rem_p0  = inp1 % inp2;
      end
`ifdef SCI_OPS_EN
      sqr_p0     = 32'(inp1) * 32'(inp1);
      root_p0    = isqrt(inp1);
      root_sq_p0 = 16'(root_p0) * 16'(root_p0);
`endif
   end

   always_comb begin
      res_a_p0 = 16'h0000;
      res_b_p0 = 16'h0000;
      case (select)
         OP_ADD: begin
            res_a_p0 = sum_p0[15:0];
            res_b_p0 = {15'b0, sum_p0[16]};
         end
         OP_SUB: begin
            res_a_p0 = diff_p0;
            res_b_p0 = {15'b0, (inp1 < inp2)};
         end
         OP_MUL: begin
            res_a_p0 = prod_p0[15:0];
            res_b_p0 = prod_p0[31:16];
         end
         OP_DIV: begin
            res_a_p0 = quot_p0;
            res_b_p0 = rem_p0;
         end
         OP_AND: res_a_p0 = inp1 & inp2;
         OP_OR:  res_a_p0 = inp1 | inp2;
         OP_XOR: res_a_p0 = inp1 ^ inp2;
         OP_NOT: begin
            res_a_p0 = ~inp1;
            res_b_p0 = ~inp2;
         end
         OP_SHL: begin
            res_a_p0 = shl_p0[15:0];
            res_b_p0 = shl_p0[31:16];
         end
         OP_SHR: res_a_p0 = inp1 >> inp2[3:0];
         OP_MAX: begin
            res_a_p0 = (inp1 >= inp2) ? inp1 : inp2;
            res_b_p0 = (inp1 >= inp2) ? inp2 : inp1;
         end
`ifdef SCI_OPS_EN
         OP_SQR: begin
            res_a_p0 = sqr_p0[15:0];
            res_b_p0 = sqr_p0[31:16];
         end
         OP_SQRT: begin
            res_a_p0 = {8'h00, root_p0};
            res_b_p0 = inp1 - root_sq_p0;
         end
         OP_FACT: begin
            res_a_p0 = fact_sat(inp1);
            res_b_p0 = {15'b0, (inp1 > 16'd8)};
         end
`endif
         default: begin
            res_a_p0 = 16'h0000;
            res_b_p0 = 16'h0000;
         end
      endcase
   end

   // p0 -> output register
   always_ff @(posedge clk) begin
      if (rst) begin
         a <= 16'h0000;
         b <= 16'h0000;
      end else begin
         a <= res_a_p0;
         b <= res_b_p0;
      end
   end

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for main: expectations are queued as stimulus is driven and checked after each edge.
// Scientific-op expectations follow whether SCI_OPS_EN is defined for the build.
module tb_main;

   logic        clk;
   logic        rst;
   logic [15:0] inp1;
   logic [15:0] inp2;
   logic [4:0]  select;
   logic [15:0] a;
   logic [15:0] b;

   main dut (
      .clk    (clk),
      .rst    (rst),
      .inp1   (inp1),
      .inp2   (inp2),
      .select (select),
      .a      (a),
      .b      (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] qa[$];
   logic [15:0] qb[$];
   string       qt[$];
   int          checks = 0;
   int          passes = 0;

   // Independent reference model.
   function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic [4:0] s,
                                 output logic [15:0] ea, output logic [15:0] eb);
      int unsigned xi, yi, sh, r, f;
      longint unsigned p;
      xi = x; yi = y; sh = y % 16;
      ea = 0; eb = 0;
      case (s)
         5'd0: begin ea = 16'((xi + yi) % 65536); eb = ((xi + yi) > 65535) ? 16'd1 : 16'd0; end
         5'd1: begin ea = 16'((xi + 65536 - yi) % 65536); eb = (xi < yi) ? 16'd1 : 16'd0; end
         5'd2: begin p = longint'(xi) * longint'(yi); ea = 16'(p % 65536); eb = 16'(p / 65536); end
         5'd3: begin
            if (yi == 0) begin ea = 16'hFFFF; eb = x; end
            else begin ea = 16'(xi / yi); eb = 16'(xi % yi); end
         end
         5'd4: ea = x & y;
         5'd5: ea = x | y;
         5'd6: ea = x ^ y;
         5'd7: begin ea = ~x; eb = ~y; end
         5'd8: begin
            ea = 16'((xi * (32'd1 << sh)) % 65536);
            eb = (sh == 0) ? 16'd0 : 16'(xi >> (16 - sh));
         end
         5'd9: ea = 16'(xi / (32'd1 << sh));
         5'd10: begin ea = (xi > yi) ? x : y; eb = (xi > yi) ? y : x; end
`ifdef SCI_OPS_EN
         5'd11: begin p = longint'(xi) * longint'(xi); ea = 16'(p % 65536); eb = 16'(p / 65536); end
         5'd12: begin
            r = 0;
            while ((r + 1) * (r + 1) <= xi) r++;
            ea = 16'(r); eb = 16'(xi - r * r);
         end
         5'd13: begin
            if (xi > 8) begin ea = 16'hFFFF; eb = 16'd1; end
            else begin
               f = 1;
               for (int k = 2; k <= int'(xi); k++) f = f * k;
               ea = 16'(f); eb = 16'd0;
            end
         end
`endif
         default: begin ea = 0; eb = 0; end
      endcase
   endfunction

   task automatic check_out();
      logic [15:0] ea, eb;
      string t;
      if (qa.size() == 0) begin
         checks++;
         $error("FAIL scoreboard_empty a=%h b=%h", a, b);
      end else begin
         ea = qa.pop_front(); eb = qb.pop_front(); t = qt.pop_front();
         checks++;
         assert (a === ea) passes++;
         else $error("FAIL %s.a observed=%h expected=%h", t, a, ea);
         checks++;
         assert (b === eb) passes++;
         else $error("FAIL %s.b observed=%h expected=%h", t, b, eb);
      end
   endtask

   // Drive one cycle with explicit expected values.
   task automatic step_exp(input logic r, input logic [15:0] x, input logic [15:0] y,
                           input logic [4:0] s, input logic [15:0] ea, input logic [15:0] eb,
                           input string t);
      rst = r; inp1 = x; inp2 = y; select = s;
      qa.push_back(ea); qb.push_back(eb); qt.push_back(t);
      @(posedge clk); #1;
      check_out();
   endtask

   // Drive one cycle with expectations from the model.
   task automatic step_mod(input logic [15:0] x, input logic [15:0] y, input logic [4:0] s,
                           input string t);
      logic [15:0] ea, eb;
      model(x, y, s, ea, eb);
      step_exp(1'b0, x, y, s, ea, eb, t);
   endtask

   initial begin
      logic [15:0] sa, sb;
      rst = 1'b1; inp1 = 0; inp2 = 0; select = 0;
      @(negedge clk);

      // Reset holds outputs at zero regardless of the operation.
      step_exp(1'b1, 16'd25, 16'd6, 5'b00011, 16'd0, 16'd0, "rst0");
      step_exp(1'b1, 16'd25, 16'd6, 5'b00011, 16'd0, 16'd0, "rst1");
      step_exp(1'b0, 16'd25, 16'd6, 5'b00011, 16'd4, 16'd1, "rst_release_div");
      step_exp(1'b1, 16'd25, 16'd6, 5'b00011, 16'd0, 16'd0, "rst_mid");
      step_exp(1'b0, 16'd25, 16'd0, 5'b00011, 16'hFFFF, 16'd25, "div_by_zero");

      step_exp(1'b0, 16'hFFFF, 16'd1, 5'b00000, 16'h0000, 16'd1, "add_wrap");
      step_exp(1'b0, 16'd3, 16'd5, 5'b00001, 16'hFFFE, 16'd1, "sub_borrow");
      step_exp(1'b0, 16'd1000, 16'd1000, 5'b00010, 16'h4240, 16'h000F, "mul_hi");
      step_exp(1'b0, 16'hF0F0, 16'h0FF0, 5'b00100, 16'h00F0, 16'd0, "and");
      step_exp(1'b0, 16'hF0F0, 16'h0FF0, 5'b00101, 16'hFFF0, 16'd0, "or");
      step_exp(1'b0, 16'hF0F0, 16'h0FF0, 5'b00110, 16'hFF00, 16'd0, "xor");
      step_exp(1'b0, 16'h1234, 16'h00FF, 5'b00111, 16'hEDCB, 16'hFF00, "not");
      step_exp(1'b0, 16'hABCD, 16'd4, 5'b01000, 16'hBCD0, 16'h000A, "shl");
      step_exp(1'b0, 16'hABCD, 16'h0014, 5'b01001, 16'h0ABC, 16'd0, "shr_low_bits");
      step_exp(1'b0, 16'd7, 16'd300, 5'b01010, 16'd300, 16'd7, "maxmin");
`ifdef SCI_OPS_EN
      step_exp(1'b0, 16'd26, 16'd99, 5'b01100, 16'd5, 16'd1, "sqrt26");
      step_exp(1'b0, 16'd8, 16'd0, 5'b01101, 16'h9D80, 16'd0, "fact8");
      step_exp(1'b0, 16'd9, 16'd0, 5'b01101, 16'hFFFF, 16'd1, "fact9");
      step_exp(1'b0, 16'd0, 16'd0, 5'b01101, 16'd1, 16'd0, "fact0");
      step_exp(1'b0, 16'd300, 16'd5, 5'b01011, 16'h5F90, 16'h0001, "square");
      step_exp(1'b0, 16'hFFFF, 16'd0, 5'b01100, 16'd255, 16'd510, "sqrt_max");
`else
      step_exp(1'b0, 16'd26, 16'd99, 5'b01100, 16'd0, 16'd0, "sqrt_off");
      step_exp(1'b0, 16'd8, 16'd0, 5'b01101, 16'd0, 16'd0, "fact_off");
      step_exp(1'b0, 16'd300, 16'd5, 5'b01011, 16'd0, 16'd0, "square_off");
`endif
      step_exp(1'b0, 16'h5A5A, 16'hA5A5, 5'b11111, 16'd0, 16'd0, "unused_11111");
      step_exp(1'b0, 16'h5A5A, 16'hA5A5, 5'b01110, 16'd0, 16'd0, "unused_01110");

      // Back-to-back random operations, one new select per cycle.
      for (int i = 0; i < 120; i++) begin
         sa = 16'($urandom);
         sb = (i % 7 == 0) ? 16'd0 : 16'($urandom_range(0, (i % 2 == 0) ? 65535 : 20));
         if (i % 5 == 0) sa = 16'($urandom_range(0, 12));
         step_mod(sa, sb, 5'($urandom_range(0, 31)), "rand");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/main.md
# main

Registered 16-bit unsigned arithmetic/logic/scientific unit at the core of the 16-bit scientific calculator. It takes two operands and a 5-bit operation code. Every clock it captures a primary result `a` and a secondary result `b` (carry, borrow, high word, remainder or flag). It is the compute core between the operand/keypad front end and the display logic.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `inp1`  in  16  operand 1, unsigned
- `inp2`  in  16  operand 2, unsigned
- `select`  in  5  operation code
- `a`  out  16  primary result, registered
- `b`  out  16  secondary result, registered

## Operation
All operands are unsigned. Results are truncated to the stated widths.

- `00000` add: `a` = (inp1+inp2)[15:0]; `b` = {15'b0, carry}.
- `00001` sub: `a` = (inp1−inp2) mod 2^16; `b` = {15'b0, inp1<inp2}.
- `00010` mul: 32-bit product; `a` = low word, `b` = high word.
- `00011` div: `a` = inp1/inp2, `b` = inp1%inp2.
  - If inp2=0: `a`=16'hFFFF, `b`=inp1.
- `00100` and: `a` = inp1&inp2; `b` = 0.
- `00101` or: `a` = inp1|inp2; `b` = 0.
- `00110` xor: `a` = inp1^inp2; `b` = 0.
- `00111` not: `a` = ~inp1; `b` = ~inp2.
- `01000` shl: `a` = inp1 << inp2[3:0]; `b` = bits shifted out, right-aligned.
- `01001` shr: `a` = inp1 >> inp2[3:0] (logical); `b` = 0.
- `01010` max/min: `a` = max(inp1,inp2); `b` = min(inp1,inp2).
- `01011` square: 32-bit inp1²; `a` = low word, `b` = high word.
- `01100` sqrt: `a` = floor(√inp1); `b` = inp1 − a².
- `01101` factorial:
  - inp1 ≤ 8: `a` = inp1!, `b` = 0 (0! = 1).
  - inp1 > 8: `a` = 16'hFFFF, `b` = 1 (overflow flag).
- All other codes (`01110`–`11111`): `a` = 0, `b` = 0.
- inp2 is ignored by sqrt, square and factorial.

## Timing
- Results are computed combinationally from inp1/inp2/select. They are registered into `a`/`b` on every rising `clk`; there is no enable and no handshake.
- Latency: 1 cycle. Inputs present before edge N appear on `a`/`b` after edge N.
- If inputs change every cycle, outputs track one cycle behind.
- Reset: when `rst`=1 at an edge, `a`=0 and `b`=0, overriding any operation.
  - Reset applied mid-stream discards that cycle's result.
  - The first non-reset edge loads the current operation's result.
- Division, sqrt and multiply must close timing at the single-cycle rate; no multicycle paths.

## Configuration
- Macro `SCI_OPS_EN`.
- Defined: codes `01011` (square), `01100` (sqrt) and `01101` (factorial) behave as specified above.
- Not defined: those three codes produce `a`=0, `b`=0 like any unused code, and their logic is not synthesised. All other operations are unaffected.

## Test plan
- Division: inp1=25, inp2=6, select=`00011`, one clock → `a`=4, `b`=1. Then inp2=0 → `a`=16'hFFFF, `b`=25.
- Add/sub wrap: 16'hFFFF + 1 (`00000`) → `a`=0, `b`=1. Then 3 − 5 (`00001`) → `a`=16'hFFFE, `b`=1.
- Multiply high word: 1000 × 1000 (`00010`) → `a`=16'h4240, `b`=16'h000F.
- Scientific (with `SCI_OPS_EN`):
  - sqrt 26 → `a`=5, `b`=1.
  - factorial 8 → `a`=16'h9D80, `b`=0.
  - factorial 9 → `a`=16'hFFFF, `b`=1.
  - Without `SCI_OPS_EN`: all three → `a`=0, `b`=0.
- Reset and latency: drive 25/6/`00011` with `rst`=1 for 2 cycles → `a`=`b`=0. Deassert `rst` → `a`=4, `b`=1 after exactly one edge. Reassert `rst` for one edge → `a`=`b`=0 on that edge.
- Unused code `11111` with any operands → `a`=0, `b`=0. Back-to-back select changes each cycle → each result appears exactly one cycle later.
